// File: rtl/seq_gen_pkg.sv
// seq_gen_pkg: shared types and defaults for the serial pattern generator.
//   state_t      transmitter FSM state (2-bit encoding)
//   GAP_DEFAULT  default idle cycles between repetitions
package seq_gen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int GAP_DEFAULT = 1;

endpackage

// File: rtl/seq_gen_shreg.sv
// seq_gen_shreg: loadable WIDTH-bit left-shift register.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   load       load din (has priority over shift)
//   shift      shift left by one, zero fill
//   din        parallel load value
//   sel        bit index (L-1) of the serial tap
//   bit_nxt    value the tap will hold after this edge, so the caller
//              can register its serial output without a cycle of lag
module seq_gen_shreg #(
   parameter int WIDTH = 8,
   parameter int LEN_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] din,
   input  logic [LEN_W-1:0] sel,
   output logic             bit_nxt
);

   logic [WIDTH-1:0] data;
   logic [WIDTH-1:0] data_nxt;
   logic [WIDTH-1:0] tap_vec;

   always_comb begin
      data_nxt = data;
      if (load)
         data_nxt = din;
      else if (shift)
         data_nxt = {data[WIDTH-2:0], 1'b0};
   end

   // variable right shift avoids an index wider than the vector needs
   assign tap_vec = data_nxt >> sel;
   assign bit_nxt = tap_vec[0];

   always_ff @(posedge clk) begin
      if (rst)
         data <= '0;
      else
         data <= data_nxt;
   end

endmodule

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: serial bit-pattern transmitter, MSB of active field first,
// repeated reps+1 times with GAP idle cycles between repetitions.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   start      begin transmission (IDLE only, ignored when len=0)
//   pattern    bits to send, active field pattern[len-1:0]
//   len        bits per repetition, clamped to WIDTH
//   reps       extra repetitions
//   abort      cancel current transmission, no done pulse
//   out        serial bit (registered, 0 when valid=0)
//   valid      out carries a pattern bit
//   busy       high outside IDLE
//   done       one-cycle pulse after the final bit
//
// state    | meaning
// ST_IDLE  | waiting for start
// ST_SHIFT | driving pattern bits, valid=1
// ST_GAP   | forced-0 idle between repetitions
// ST_DONE  | done pulse, then back to IDLE
module seq_pattern_gen
   import seq_gen_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int LEN_W = 4,
   parameter int REP_W = 4,
   parameter int GAP   = GAP_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] pattern,
   input  logic [LEN_W-1:0] len,
   input  logic [REP_W-1:0] reps,
   input  logic             abort,
   output logic             out,
   output logic             valid,
   output logic             busy,
   output logic             done
);

   localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(GAP > 0 ? GAP - 1 : 0);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] pat_q, pat_nxt;
   logic [LEN_W-1:0] l_q, l_nxt;
   logic [LEN_W-1:0] bitcnt, bitcnt_nxt;
   logic [REP_W-1:0] repcnt, repcnt_nxt;
   logic [GAP_W-1:0] gapcnt, gapcnt_nxt;
   logic [LEN_W-1:0] len_eff;
   logic [WIDTH-1:0] load_src;
   logic [LEN_W-1:0] sel;
   logic             load, shift, bit_nxt;

   assign len_eff = (len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len;
   // tap follows the length that will be in force after this edge
   assign sel     = l_nxt - LEN_W'(1);

   seq_gen_shreg #(.WIDTH(WIDTH), .LEN_W(LEN_W)) u_shreg (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .shift   (shift),
      .din     (load_src),
      .sel     (sel),
      .bit_nxt (bit_nxt)
   );

   always_comb begin
      state_nxt  = state;
      pat_nxt    = pat_q;
      l_nxt      = l_q;
      bitcnt_nxt = bitcnt;
      repcnt_nxt = repcnt;
      gapcnt_nxt = gapcnt;
      load       = 1'b0;
      shift      = 1'b0;
      load_src   = pat_q;
      case (state)
         ST_IDLE: begin
            if (start && len != '0) begin
               state_nxt  = ST_SHIFT;
               pat_nxt    = pattern;
               l_nxt      = len_eff;
               load       = 1'b1;
               load_src   = pattern;
               bitcnt_nxt = len_eff - LEN_W'(1);
               repcnt_nxt = reps;
            end
         end
         ST_SHIFT: begin
            if (bitcnt != '0) begin
               shift      = 1'b1;
               bitcnt_nxt = bitcnt - LEN_W'(1);
            end else if (repcnt != '0) begin
               if (GAP > 0) begin
                  state_nxt  = ST_GAP;
                  gapcnt_nxt = GAP_INIT;
               end else begin
                  load       = 1'b1;
                  bitcnt_nxt = l_q - LEN_W'(1);
                  repcnt_nxt = repcnt - REP_W'(1);
               end
            end else begin
               state_nxt = ST_DONE;
            end
         end
         ST_GAP: begin
            if (gapcnt != '0) begin
               gapcnt_nxt = gapcnt - GAP_W'(1);
            end else begin
               state_nxt  = ST_SHIFT;
               load       = 1'b1;
               bitcnt_nxt = l_q - LEN_W'(1);
               repcnt_nxt = repcnt - REP_W'(1);
            end
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
      if (abort && state != ST_IDLE) begin
         state_nxt = ST_IDLE;
         load      = 1'b0;
         shift     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         pat_q  <= '0;
         l_q    <= '0;
         bitcnt <= '0;
         repcnt <= '0;
         gapcnt <= '0;
         out    <= 1'b0;
         valid  <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= state_nxt;
         pat_q  <= pat_nxt;
         l_q    <= l_nxt;
         bitcnt <= bitcnt_nxt;
         repcnt <= repcnt_nxt;
         gapcnt <= gapcnt_nxt;
         out    <= (state_nxt == ST_SHIFT) && bit_nxt;
         valid  <= (state_nxt == ST_SHIFT);
         busy   <= (state_nxt != ST_IDLE);
         done   <= (state_nxt == ST_DONE);
      end
   end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Bench for seq_pattern_gen: two instances (GAP=0 and GAP=1) share stimulus;
// per-cycle {busy,done,valid,out} is compared against a stream model.
module tb_seq_pattern_gen;

   logic       clk = 1'b0;
   logic       rst, start, abort;
   logic [7:0] pattern;
   logic [3:0] len, reps;
   logic       out0, valid0, busy0, done0;
   logic       out1, valid1, busy1, done1;

   int n_checks = 0;
   int n_fail   = 0;

   logic [3:0] obs   [2][64];
   logic [3:0] exp_q [2][64];

   always #5 clk = ~clk;

   seq_pattern_gen #(.WIDTH(8), .LEN_W(4), .REP_W(4), .GAP(0)) dut0 (
      .clk(clk), .rst(rst), .start(start), .pattern(pattern), .len(len),
      .reps(reps), .abort(abort), .out(out0), .valid(valid0), .busy(busy0),
      .done(done0));

   seq_pattern_gen #(.WIDTH(8), .LEN_W(4), .REP_W(4), .GAP(1)) dut1 (
      .clk(clk), .rst(rst), .start(start), .pattern(pattern), .len(len),
      .reps(reps), .abort(abort), .out(out1), .valid(valid1), .busy(busy1),
      .done(done1));

   // expected {busy,done,valid,out} per cycle after the start edge;
   // entries after cut are idle (abort or reset sampled at the next edge)
   task automatic model(input logic [7:0] p, input logic [3:0] ln,
                        input logic [3:0] rp, input int cut);
      int l, idx;
      for (int g = 0; g < 2; g++) begin
         for (int c = 0; c < 64; c++) exp_q[g][c] = 4'b0000;
         if (ln != 0) begin
            l   = (ln > 8) ? 8 : int'(ln);
            idx = 0;
            for (int r = 0; r <= int'(rp); r++) begin
               for (int i = l - 1; i >= 0; i--) begin
                  exp_q[g][idx] = {1'b1, 1'b0, 1'b1, p[i]};
                  idx++;
               end
               if (r < int'(rp) && g == 1) begin
                  exp_q[g][idx] = 4'b1000;
                  idx++;
               end
            end
            exp_q[g][idx] = 4'b1100;
         end
         if (cut >= 0)
            for (int c = cut + 1; c < 64; c++) exp_q[g][c] = 4'b0000;
      end
   endtask

   task automatic kick(input logic [7:0] p, input logic [3:0] ln, input logic [3:0] rp);
      @(negedge clk);
      pattern = p;
      len     = ln;
      reps    = rp;
      start   = 1'b1;
   endtask

   task automatic capture(input int n, input int abort_at, input int rst_at,
                          input int restart_at, input bit scramble);
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         start = 1'b0;
         abort = 1'b0;
         rst   = 1'b0;
         obs[0][c] = {busy0, done0, valid0, out0};
         obs[1][c] = {busy1, done1, valid1, out1};
         if (scramble) begin
            pattern = 8'($urandom);
            len     = 4'($urandom);
            reps    = 4'($urandom);
         end
         if (c == abort_at)   abort = 1'b1;
         if (c == rst_at)     rst   = 1'b1;
         if (c == restart_at) start = 1'b1;
      end
      start = 1'b0;
      abort = 1'b0;
      rst   = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b1; abort = 1'b0;
      pattern = 8'hFF; len = 4'd4; reps = 4'd0;
      repeat (3) @(negedge clk);
      obs[0][0] = {busy0, done0, valid0, out0};
      obs[1][0] = {busy1, done1, valid1, out1};
      rst = 1'b0; start = 1'b0;
      for (int g = 0; g < 2; g++) begin
         n_checks++;
         if (obs[g][0] !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset gap=%0d got %b want 0000", g, obs[g][0]);
         end
      end
   endtask

   task automatic test_basic;
      kick(8'h0F, 4'd4, 4'd0);
      capture(8, -1, -1, -1, 1'b0);
      model(8'h0F, 4'd4, 4'd0, -1);
      for (int c = 0; c < 8; c++)
         for (int g = 0; g < 2; g++) begin
            n_checks++;
            if (obs[g][c] !== exp_q[g][c]) begin
               n_fail++;
               $display("FAIL basic gap=%0d cyc=%0d got %b want %b", g, c, obs[g][c], exp_q[g][c]);
            end
         end
   endtask

   task automatic test_gap;
      kick(8'hA5, 4'd8, 4'd1);
      capture(22, -1, -1, -1, 1'b1);
      model(8'hA5, 4'd8, 4'd1, -1);
      for (int c = 0; c < 22; c++)
         for (int g = 0; g < 2; g++) begin
            n_checks++;
            if (obs[g][c] !== exp_q[g][c]) begin
               n_fail++;
               $display("FAIL gap_reps gap=%0d cyc=%0d got %b want %b", g, c, obs[g][c], exp_q[g][c]);
            end
         end
   endtask

   task automatic test_back_to_back;
      kick(8'h03, 4'd2, 4'd2);
      capture(12, -1, -1, -1, 1'b0);
      model(8'h03, 4'd2, 4'd2, -1);
      for (int c = 0; c < 12; c++)
         for (int g = 0; g < 2; g++) begin
            n_checks++;
            if (obs[g][c] !== exp_q[g][c]) begin
               n_fail++;
               $display("FAIL back_to_back gap=%0d cyc=%0d got %b want %b", g, c, obs[g][c], exp_q[g][c]);
            end
         end
   endtask

   task automatic test_len_edges;
      kick(8'hFF, 4'd0, 4'd3);
      capture(4, -1, -1, -1, 1'b0);
      model(8'hFF, 4'd0, 4'd3, -1);
      for (int c = 0; c < 4; c++)
         for (int g = 0; g < 2; g++) begin
            n_checks++;
            if (obs[g][c] !== exp_q[g][c]) begin
               n_fail++;
               $display("FAIL len_zero gap=%0d cyc=%0d got %b want %b", g, c, obs[g][c], exp_q[g][c]);
            end
         end
      kick(8'h3C, 4'd12, 4'd0);
      capture(12, -1, -1, -1, 1'b0);
      model(8'h3C, 4'd12, 4'd0, -1);
      for (int c = 0; c < 12; c++)
         for (int g = 0; g < 2; g++) begin
            n_checks++;
            if (obs[g][c] !== exp_q[g][c]) begin
               n_fail++;
               $display("FAIL len_clamp gap=%0d cyc=%0d got %b want %b", g, c, obs[g][c], exp_q[g][c]);
            end
         end
   endtask

   task automatic test_abort_restart;
      kick(8'hB6, 4'd8, 4'd1);
      capture(24, 2, -1, -1, 1'b0);
      model(8'hB6, 4'd8, 4'd1, 2);
      for (int c = 0; c < 24; c++)
         for (int g = 0; g < 2; g++) begin
            n_checks++;
            if (obs[g][c] !== exp_q[g][c]) begin
               n_fail++;
               $display("FAIL abort gap=%0d cyc=%0d got %b want %b", g, c, obs[g][c], exp_q[g][c]);
            end
         end
      // start while shifting (c=1) and while in DONE (c=3) must be dropped
      for (int k = 1; k <= 3; k += 2) begin
         kick(8'h05, 4'd3, 4'd0);
         capture(8, -1, -1, k, 1'b0);
         model(8'h05, 4'd3, 4'd0, -1);
         for (int c = 0; c < 8; c++)
            for (int g = 0; g < 2; g++) begin
               n_checks++;
               if (obs[g][c] !== exp_q[g][c]) begin
                  n_fail++;
                  $display("FAIL restart_at%0d gap=%0d cyc=%0d got %b want %b", k, g, c, obs[g][c], exp_q[g][c]);
               end
            end
      end
   endtask

   task automatic test_rst_mid;
      kick(8'hC3, 4'd8, 4'd1);
      capture(24, -1, 2, -1, 1'b0);
      model(8'hC3, 4'd8, 4'd1, 2);
      for (int c = 0; c < 24; c++)
         for (int g = 0; g < 2; g++) begin
            n_checks++;
            if (obs[g][c] !== exp_q[g][c]) begin
               n_fail++;
               $display("FAIL rst_mid gap=%0d cyc=%0d got %b want %b", g, c, obs[g][c], exp_q[g][c]);
            end
         end
      kick(8'h81, 4'd8, 4'd0);
      capture(12, -1, -1, -1, 1'b0);
      model(8'h81, 4'd8, 4'd0, -1);
      for (int c = 0; c < 12; c++)
         for (int g = 0; g < 2; g++) begin
            n_checks++;
            if (obs[g][c] !== exp_q[g][c]) begin
               n_fail++;
               $display("FAIL after_rst gap=%0d cyc=%0d got %b want %b", g, c, obs[g][c], exp_q[g][c]);
            end
         end
   endtask

   task automatic test_random;
      logic [7:0] p;
      logic [3:0] ln, rp;
      int         cut;
      for (int it = 0; it < 12; it++) begin
         p   = 8'($urandom);
         ln  = 4'($urandom_range(0, 12));
         rp  = 4'($urandom_range(0, 3));
         cut = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : -1;
         kick(p, ln, rp);
         capture(48, cut, -1, -1, 1'b1);
         model(p, ln, rp, cut);
         for (int c = 0; c < 48; c++)
            for (int g = 0; g < 2; g++) begin
               n_checks++;
               if (obs[g][c] !== exp_q[g][c]) begin
                  n_fail++;
                  $display("FAIL random it=%0d p=%h len=%0d reps=%0d cut=%0d gap=%0d cyc=%0d got %b want %b",
                           it, p, ln, rp, cut, g, c, obs[g][c], exp_q[g][c]);
               end
            end
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_gap;
      test_back_to_back;
      test_len_edges;
      test_abort_restart;
      test_rst_mid;
      test_random;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
